tc_acquire_arbiter: RTL
=======================

Name: tc_acquire_arbiter

Overview:
- Shares the single TileLink acquire/grant port of TagCacheTop among NREQ uncached requesters (trace engines, DMA, tag-flush logic).
- Arbitrates acquires round-robin and keeps PutBlock bursts atomic.
- Prefixes client_xact_id with the requester index and routes grants back by decoding that prefix.
- Caps outstanding transactions per requester.

Parameters:
NREQ, 4, number of requesters (power of 2, >=2)
TLAW, `ROCKET_PADDR_WIDTH, physical address width; addr_block is TLAW-6 bits
TLDW, 64, beat data width
TLTW, `TagBits, tag width per beat
TLCIS, 7, downstream client_xact_id width; must equal REQ_XID_W+log2(NREQ)
REQ_XID_W, 5, per-requester xact id width
TLBS, 8, beats per block
MAX_OUTST, 4, outstanding transactions allowed per requester

Ports:
clk  in  1  clock
rstn  in  1  reset
req_acq_valid  in  NREQ  per-requester acquire valid
req_acq_ready  out  NREQ  per-requester acquire ready
req_acq_addr_block  in  NREQ x (TLAW-6)  block address
req_acq_xact_id  in  NREQ x REQ_XID_W  local xact id
req_acq_beat  in  NREQ x 3  addr_beat
req_acq_a_type  in  NREQ x 3  builtin a_type
req_acq_union  in  NREQ x 13  union field
req_acq_data  in  NREQ x TLDW  put data
req_acq_tag  in  NREQ x TLTW  put tag
out_acq_valid/ready/addr_block/client_xact_id/addr_beat/a_type/union/data/tag  out/in  1/1/TLAW-6/TLCIS/3/3/13/TLDW/TLTW  acquire to tag cache; is_builtin_type driven 1
out_gnt_valid  in  1  grant valid from tag cache
out_gnt_ready  out  1  grant ready
out_gnt_client_xact_id/addr_beat/g_type/data/tag  in  TLCIS/3/4/TLDW/TLTW  grant fields
req_gnt_valid  out  NREQ  one-hot grant valid
req_gnt_ready  in  NREQ  per-requester grant ready
req_gnt_xact_id/addr_beat/g_type/data/tag  out  REQ_XID_W/3/4/TLDW/TLTW  broadcast grant fields
outst_cnt  out  NREQ x log2(MAX_OUTST+1)  outstanding count per requester
err_unexp_gnt  out  1  sticky: grant for a requester with zero outstanding

Behaviour:
- Reset: async, active-low. Clock is clk, reset is rstn. State is IDLE, rr_ptr=0, all outst_cnt=0, err_unexp_gnt=0. Grant valids/readies are combinational and carry no state.
- Eligible(i) = req_acq_valid[i] && (outst_cnt[i] < MAX_OUTST || i is the locked owner in BURST).
- FSM IDLE: winner is the first eligible index at or after rr_ptr, wrapping modulo NREQ. Acquire passes through combinationally (zero latency). out_acq_client_xact_id = {winner, req_acq_xact_id[winner]}.
- req_acq_ready[i] = (i==winner) && out_acq_ready. All other readies are 0.
- IDLE, on handshake:
  - rr_ptr <= winner+1 (wraps).
  - outst_cnt[winner]++.
  - If a_type==PutBlock (3'd3) and beat != TLBS-1: owner <= winner, go to BURST.
- BURST: only the owner is considered. Each handshake is one beat. On the handshake with beat==TLBS-1, return to IDLE. outst_cnt does not increment in BURST. rr_ptr is frozen.
- Grant routing: dst = out_gnt_client_xact_id[TLCIS-1:REQ_XID_W]. req_gnt_valid[dst] = out_gnt_valid. out_gnt_ready = req_gnt_ready[dst].
- Grant completion: on a grant handshake that is final, outst_cnt[dst]--. Final means g_type != GetDataBlock (4'd5), or beat==TLBS-1.
- Simultaneous increment and decrement on the same requester in one cycle: net unchanged.
- Decrement when outst_cnt[dst]==0: counter holds at 0 and err_unexp_gnt <= 1 (sticky until reset).
- Requester at MAX_OUTST: excluded from arbitration, ready=0, and rr_ptr skips it. Grants to it are still delivered.
- Reset asserted mid-burst: FSM and counters clear immediately. The downstream is reset together with the arbiter by system convention.

Optional Feature:
TC_ARB_PFC_EN: adds per-requester 32-bit stall counters. pfc_stall output is NREQ x 32; the pfc_clr input is 1 bit.
- A counter increments each cycle that req_acq_valid[i] && !req_acq_ready[i].
- Counters saturate at 2^32-1, clear synchronously on pfc_clr, and reset to 0.
- Without the macro, neither port nor logic exists.

Decomposition:
- Package tc_arb_pkg holds:
  - the a_type constants (PutBlock=3'd3, GetBlock=3'd1, Put=3'd2);
  - the g_type constants (GetDataBlock=4'd5, PutAck=4'd3);
  - the arb_state_t enum {IDLE, BURST};
  - the acquire beat struct typedef.
- One sub-module, tc_rr_picker: a combinational round-robin priority picker (request mask plus pointer in; one-hot winner plus valid out).

Test Plan:
- All 4 requesters issue single-beat Get with out_acq_ready=1 held, rr_ptr=0 -> accepts in order 0,1,2,3,0; client_xact_id upper 2 bits match the index.
- Requester 1 issues PutBlock beats 0..7 while req 0 and req 2 are valid -> 8 consecutive beats from req 1, then req 2 wins. outst_cnt[1] rises 0->1 once only.
- Requester 3 issues 4 Gets with no grants -> 5th acquire is blocked with ready=0. A GetDataBlock grant beat 7 to id {3,x} -> count 4->3 and req 3 is accepted next cycle.
- Same-cycle acquire handshake and final grant for requester 2 at count 2 -> count stays 2.
- Grant with xact prefix 0 while outst_cnt[0]=0 -> err_unexp_gnt=1 and stays 1; the counter stays 0.
- rstn low during beat 4 of a PutBlock -> all req_acq_ready=0 and outst_cnt=0. After release, requester 0 wins IDLE arbitration.

Source files
------------

// File: rtl/tc_arb_pkg.sv
// Shared types and constants for the TagCache acquire arbiter.
// Address/tag widths follow `ROCKET_PADDR_WIDTH / `TagBits when the SoC defines them.
`ifndef ROCKET_PADDR_WIDTH
`define ROCKET_PADDR_WIDTH 32
`endif
`ifndef TagBits
`define TagBits 4
`endif

package tc_arb_pkg;
    localparam int TLAW = `ROCKET_PADDR_WIDTH;
    localparam int TLDW = 64;
    localparam int TLTW = `TagBits;
    localparam int ABW  = TLAW - 6;

    localparam logic [2:0] A_GETBLOCK = 3'd1;
    localparam logic [2:0] A_PUT      = 3'd2;
    localparam logic [2:0] A_PUTBLOCK = 3'd3;

    localparam logic [3:0] G_PUTACK       = 4'd3;
    localparam logic [3:0] G_GETDATABLOCK = 4'd5;

    typedef enum logic {IDLE, BURST} arb_state_t;

    typedef struct packed {
        logic [ABW-1:0]  addr_block;
        logic [2:0]      beat;
        logic [2:0]      a_type;
        logic [12:0]     union_bits;
        logic [TLDW-1:0] data;
        logic [TLTW-1:0] tag;
    } acq_beat_t;
endpackage

// File: rtl/tc_acquire_arbiter_if.sv
// Requester-side and tag-cache-side acquire/grant bundle of the arbiter.
// slave: arbiter view; master: the surrounding environment's view.
interface tc_acquire_arbiter_if
    import tc_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int REQ_XID_W = 5,
    parameter int TLCIS     = 7
);
    logic [NREQ-1:0]                 req_acq_valid;
    logic [NREQ-1:0]                 req_acq_ready;
    logic [NREQ-1:0][ABW-1:0]        req_acq_addr_block;
    logic [NREQ-1:0][REQ_XID_W-1:0]  req_acq_xact_id;
    logic [NREQ-1:0][2:0]            req_acq_beat;
    logic [NREQ-1:0][2:0]            req_acq_a_type;
    logic [NREQ-1:0][12:0]           req_acq_union;
    logic [NREQ-1:0][TLDW-1:0]       req_acq_data;
    logic [NREQ-1:0][TLTW-1:0]       req_acq_tag;

    logic                 out_acq_valid;
    logic                 out_acq_ready;
    logic [ABW-1:0]       out_acq_addr_block;
    logic [TLCIS-1:0]     out_acq_client_xact_id;
    logic [2:0]           out_acq_addr_beat;
    logic [2:0]           out_acq_a_type;
    logic [12:0]          out_acq_union;
    logic [TLDW-1:0]      out_acq_data;
    logic [TLTW-1:0]      out_acq_tag;
    logic                 out_acq_is_builtin_type;

    logic                 out_gnt_valid;
    logic                 out_gnt_ready;
    logic [TLCIS-1:0]     out_gnt_client_xact_id;
    logic [2:0]           out_gnt_addr_beat;
    logic [3:0]           out_gnt_g_type;
    logic [TLDW-1:0]      out_gnt_data;
    logic [TLTW-1:0]      out_gnt_tag;

    logic [NREQ-1:0]      req_gnt_valid;
    logic [NREQ-1:0]      req_gnt_ready;
    logic [REQ_XID_W-1:0] req_gnt_xact_id;
    logic [2:0]           req_gnt_addr_beat;
    logic [3:0]           req_gnt_g_type;
    logic [TLDW-1:0]      req_gnt_data;
    logic [TLTW-1:0]      req_gnt_tag;

    modport slave (
        input  req_acq_valid, req_acq_addr_block, req_acq_xact_id, req_acq_beat,
               req_acq_a_type, req_acq_union, req_acq_data, req_acq_tag,
        output req_acq_ready,
        output out_acq_valid, out_acq_addr_block, out_acq_client_xact_id, out_acq_addr_beat,
               out_acq_a_type, out_acq_union, out_acq_data, out_acq_tag, out_acq_is_builtin_type,
        input  out_acq_ready,
        input  out_gnt_valid, out_gnt_client_xact_id, out_gnt_addr_beat, out_gnt_g_type,
               out_gnt_data, out_gnt_tag,
        output out_gnt_ready,
        output req_gnt_valid, req_gnt_xact_id, req_gnt_addr_beat, req_gnt_g_type,
               req_gnt_data, req_gnt_tag,
        input  req_gnt_ready
    );

    modport master (
        output req_acq_valid, req_acq_addr_block, req_acq_xact_id, req_acq_beat,
               req_acq_a_type, req_acq_union, req_acq_data, req_acq_tag,
        input  req_acq_ready,
        input  out_acq_valid, out_acq_addr_block, out_acq_client_xact_id, out_acq_addr_beat,
               out_acq_a_type, out_acq_union, out_acq_data, out_acq_tag, out_acq_is_builtin_type,
        output out_acq_ready,
        output out_gnt_valid, out_gnt_client_xact_id, out_gnt_addr_beat, out_gnt_g_type,
               out_gnt_data, out_gnt_tag,
        input  out_gnt_ready,
        input  req_gnt_valid, req_gnt_xact_id, req_gnt_addr_beat, req_gnt_g_type,
               req_gnt_data, req_gnt_tag,
        output req_gnt_ready
    );
endinterface

// File: rtl/tc_acquire_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module tc_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);
    logic [IW-1:0] k;

    // Walk from farthest to nearest offset so the nearest hit is the last write.
    always_comb begin
        gnt_o = '0;
        idx_o = ptr_i;
        vld_o = 1'b0;
        k     = '0;
        for (int o = N - 1; o >= 0; o--) begin
            k = ptr_i + IW'(o);
            if (req_i[k]) begin
                idx_o = k;
                vld_o = 1'b1;
            end
        end
        if (vld_o) gnt_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/tc_acquire_arbiter.sv
// Round-robin acquire arbiter for the TagCache port with atomic PutBlock bursts,
// xact-id prefix grant routing and per-requester outstanding caps. Option: TC_ARB_PFC_EN.
module tc_acquire_arbiter
    import tc_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int REQ_XID_W = 5,
    parameter int TLCIS     = 7,
    parameter int TLBS      = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic clk,
    input  logic rstn,
    tc_acquire_arbiter_if.slave bus,
    output logic [NREQ-1:0][$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic err_unexp_gnt
`ifdef TC_ARB_PFC_EN
    ,
    input  logic                  pfc_clr,
    output logic [NREQ-1:0][31:0] pfc_stall
`endif
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [2:0]    LAST_BEAT = 3'(TLBS - 1);
    localparam logic [CW-1:0] CMAX      = CW'(MAX_OUTST);

    arb_state_t              state_q, state_d;
    logic [IW-1:0]           rr_q, rr_d, owner_q, owner_d;
    logic [NREQ-1:0][CW-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [NREQ-1:0] elig, win_oh, inc, dec;
    logic [IW-1:0]   win_idx, dst;
    logic            win_vld, acq_fire, gnt_fire, gnt_final;
    acq_beat_t       win;

    // In a burst only the owner may proceed, regardless of its count.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            elig[i] = bus.req_acq_valid[i] &&
                      ((state_q == IDLE) ? (cnt_q[i] < CMAX) : (owner_q == IW'(i)));
    end

    tc_rr_picker #(.N(NREQ)) u_pick (
        .req_i (elig),
        .ptr_i (rr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    always_comb begin
        win.addr_block = bus.req_acq_addr_block[win_idx];
        win.beat       = bus.req_acq_beat[win_idx];
        win.a_type     = bus.req_acq_a_type[win_idx];
        win.union_bits = bus.req_acq_union[win_idx];
        win.data       = bus.req_acq_data[win_idx];
        win.tag        = bus.req_acq_tag[win_idx];
    end

    // No acquire may be offered or accepted while held in reset.
    assign acq_fire                   = win_vld && rstn && bus.out_acq_ready;
    assign bus.out_acq_valid          = win_vld && rstn;
    assign bus.req_acq_ready          = acq_fire ? win_oh : '0;
    assign bus.out_acq_client_xact_id = {win_idx, bus.req_acq_xact_id[win_idx]};
    assign bus.out_acq_addr_block     = win.addr_block;
    assign bus.out_acq_addr_beat      = win.beat;
    assign bus.out_acq_a_type         = win.a_type;
    assign bus.out_acq_union          = win.union_bits;
    assign bus.out_acq_data           = win.data;
    assign bus.out_acq_tag            = win.tag;
    assign bus.out_acq_is_builtin_type = 1'b1;

    assign dst                   = bus.out_gnt_client_xact_id[TLCIS-1:REQ_XID_W];
    assign bus.req_gnt_valid     = bus.out_gnt_valid ? (NREQ'(1) << dst) : '0;
    assign bus.out_gnt_ready     = bus.req_gnt_ready[dst];
    assign bus.req_gnt_xact_id   = bus.out_gnt_client_xact_id[REQ_XID_W-1:0];
    assign bus.req_gnt_addr_beat = bus.out_gnt_addr_beat;
    assign bus.req_gnt_g_type    = bus.out_gnt_g_type;
    assign bus.req_gnt_data      = bus.out_gnt_data;
    assign bus.req_gnt_tag       = bus.out_gnt_tag;
    assign gnt_fire  = bus.out_gnt_valid && bus.out_gnt_ready;
    assign gnt_final = (bus.out_gnt_g_type != G_GETDATABLOCK) || (bus.out_gnt_addr_beat == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: if (acq_fire) begin
                rr_d = win_idx + IW'(1);
                if (win.a_type == A_PUTBLOCK && win.beat != LAST_BEAT) begin
                    owner_d = win_idx;
                    state_d = BURST;
                end
            end
            BURST: if (acq_fire && win.beat == LAST_BEAT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A burst counts as one transaction: only the first (IDLE) beat increments.
    assign inc = (acq_fire && state_q == IDLE) ? win_oh : '0;
    assign dec = (gnt_fire && gnt_final) ? bus.req_gnt_valid : '0;

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (inc[i] && !dec[i]) cnt_d[i] = cnt_q[i] + CW'(1);
            else if (dec[i] && !inc[i]) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign outst_cnt     = cnt_q;
    assign err_unexp_gnt = err_q;

`ifdef TC_ARB_PFC_EN
    logic [NREQ-1:0][31:0] pfc_q, pfc_d;

    always_comb begin
        pfc_d = pfc_q;
        for (int i = 0; i < NREQ; i++) begin
            if (pfc_clr) pfc_d[i] = '0;
            else if (bus.req_acq_valid[i] && !bus.req_acq_ready[i] && pfc_q[i] != '1)
                pfc_d[i] = pfc_q[i] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pfc_q <= '0;
        else       pfc_q <= pfc_d;
    end

    assign pfc_stall = pfc_q;
`endif
endmodule
